// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode encoding and slot-state type for the logic-unit arbiter slice.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSV  = 3'd7;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between N_REQ clients and the shared logic unit.
interface logic_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  import logic_unit_pkg::*;

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [OP_W*N_REQ-1:0]  req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic [15:0]            done_cnt;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, done_cnt
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, done_cnt
  );

endinterface

// File: rtl/logic_unit_arbiter_op_unit.sv
// Combinational bitwise evaluator; opcode 7 yields zero data with err set.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic_op_unit between N_REQ requesters with a
// single registered response slot.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  logic_unit_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);

  slot_state_e      state_q;
  logic [IDW-1:0]   prio_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [15:0]      done_cnt_q;

  logic               rsp_valid;
  logic               can_accept;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDW-1:0]     ff_idx;
  logic               any_vld;
  logic [IDW:0]       sum;
  logic [IDW-1:0]     gnt_idx;
  logic               grant;
  logic [IDW-1:0]     prio_d;

  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] op_y;
  logic             op_err;

  assign rsp_valid  = (state_q == SLOT_FULL);
  assign can_accept = !rsp_valid || bus.rsp_ready;

  // Rotate so prio_q sits at bit 0, find first set, then map back to an index.
  always_comb begin
    dbl     = {bus.req_valid, bus.req_valid} >> prio_q;
    rot     = dbl[N_REQ-1:0];
    ff_idx  = '0;
    any_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        ff_idx  = IDW'(k);
        any_vld = 1'b1;
      end
    end
    sum     = {1'b0, ff_idx} + {1'b0, prio_q};
    gnt_idx = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];
    prio_d  = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Held off during reset so nothing is accepted that would be discarded.
  assign grant         = rst_n && can_accept && any_vld;
  assign bus.req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

  assign sel_op = bus.req_op[gnt_idx*OP_W +: OP_W];
  assign sel_a  = bus.req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[gnt_idx*WIDTH +: WIDTH];

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (op_y),
    .err (op_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      prio_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (rsp_valid && bus.rsp_ready) done_cnt_q <= done_cnt_q + 16'd1;
      if (grant) begin
        prio_q     <= prio_d;
        rsp_id_q   <= gnt_idx;
        rsp_data_q <= op_y;
        rsp_err_q  <= op_err;
      end
      case (state_q)
        SLOT_EMPTY: if (grant) state_q <= SLOT_FULL;
        SLOT_FULL:  if (bus.rsp_ready && !grant) state_q <= SLOT_EMPTY;
        default:    state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.done_cnt  = done_cnt_q;

endmodule
